// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage controller for the 5-stage MIPS core.
// It owns the fetch address and issues one imem request at a time over a
// valid/ready handshake. It presents each fetched word to IF/ID and applies
// redirects from ID. A fetch that is in flight when a redirect arrives is
// squashed: the handshake still completes, but the returned data is dropped.
// Optional feature macro: FETCH_PERF_CNT_EN adds the outputs redirect_cnt and
// stall_cnt. Both are saturating performance counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        flush
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      state_q;
  logic        req_q, valid_q, flush_q, squash_q;
  logic [31:0] addr_q, pc_q, instr_q, tgt_q;

  logic        redir;
  logic [31:0] redir_tgt;
  logic        capture;

  // A taken branch has priority over a jump. The target is word-aligned here.
  assign redir     = (branch & branch_taken) | jump;
  assign redir_tgt = ((branch & branch_taken) ? branch_target : jump_target)
                     & 32'hFFFF_FFFC;
  // Live data lands only in WAIT, when the fetch is not squashed and no
  // redirect arrives on the same edge.
  assign capture   = (state_q == WAIT) & imem_rvalid & ~squash_q & ~redir;

  // Fetch FSM and the registered IF/ID outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0000;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      squash_q <= 1'b0;
      tgt_q    <= RESET_PC;
    end else begin
      flush_q <= redir;
      if (redir) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= 1'b1;
        instr_q <= imem_rdata;
        pc_q    <= addr_q;
      end else if (!stall) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        BOOT: begin
          if (redir) addr_q <= redir_tgt;
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          // The address stays put until it is accepted. A redirect is parked
          // in tgt_q and takes effect after the squashed return.
          if (redir) begin
            squash_q <= 1'b1;
            tgt_q    <= redir_tgt;
          end
          if (imem_ready) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            squash_q <= 1'b0;
            if (redir) begin
              addr_q  <= redir_tgt;
              state_q <= REQ;
              req_q   <= 1'b1;
            end else if (squash_q) begin
              addr_q  <= tgt_q;
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              addr_q <= addr_q + 32'd4;
              if (stall) begin
                state_q <= HOLD;
                req_q   <= 1'b0;
              end else begin
                state_q <= REQ;
                req_q   <= 1'b1;
              end
            end
          end else if (redir) begin
            squash_q <= 1'b1;
            tgt_q    <= redir_tgt;
          end
        end
        HOLD: begin
          if (redir) begin
            addr_q  <= redir_tgt;
            state_q <= REQ;
            req_q   <= 1'b1;
          end else if (!stall) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign pc        = pc_q;
  assign flush     = flush_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redir_cnt_q, stall_cnt_q;

  // Saturating counts of accepted redirects and of stalled live instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (redir && redir_cnt_q != 32'hFFFF_FFFF) redir_cnt_q <= redir_cnt_q + 32'd1;
      if (valid_q && stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt = redir_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule
